// File: rtl/mips_ctrl_pkg.sv
// Shared control encodings for the MIPS pipeline
// Interrupt FSM states and trap-path mux codes
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GUARD   = 2'd3
  } irq_state_e;

  // PCSrc selects: the trap vector rides the jump path
  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_JR     = 2'd3;

  // RegDst selects: traps link into $26
  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_RA  = 2'd2;
  localparam logic [1:0] REGDST_EPC = 2'd3;

  localparam logic [4:0] EPC_REG = 5'd26;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder
// Index 0 wins; any flags a non-empty request vector
module irq_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] sel_o,
  output logic         any_o
);

  // scan high to low so the lowest set index lands last
  always_comb begin
    sel_o = '0;
    any_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) sel_o = W'(i);
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the 5-stage pipeline
// Edge-detects sources, injects IRQ into safe ID slots
module irq_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int CAUSE_W      = 2,
  parameter int GUARD_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_SRC-1:0]   irq_src,
  input  logic [N_SRC-1:0]   irq_en,
  input  logic [N_SRC-1:0]   irq_clr,
  input  logic               id_valid,
  input  logic               stall,
  input  logic               branch_flush,
  input  logic               pc_kernel,
  input  logic               exc_taken,
  input  logic               eret,
  output logic               IRQ,
  output logic [CAUSE_W-1:0] irq_cause,
  output logic [N_SRC-1:0]   irq_pending,
  output logic               in_service,
  output logic [CNT_W-1:0]   irq_count
);

  localparam int GW =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD =
    GW'(GUARD_CYCLES - 1);

  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  irq_state_e         state_q, state_d;
  logic [GW-1:0]      guard_q, guard_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [N_SRC-1:0]   rise;
  logic [CAUSE_W-1:0] sel;
  logic               any;
  logic               slot;
  logic               irq;
  logic               req_nxt;

  irq_prio_enc #(
    .N (N_SRC),
    .W (CAUSE_W)
  ) u_prio (
    .req_i (pending_q & irq_en),
    .sel_o (sel),
    .any_o (any)
  );

  // injection decision and pending/counter datapath
  always_comb begin
    rise = irq_src & ~src_q;
    slot = id_valid & ~stall & ~branch_flush
         & ~pc_kernel;
    irq  = (state_q == ST_PENDING) & any & slot
         & ~exc_taken;
    pending_d = (pending_q & ~irq_clr)
              | (rise & irq_en);
    if (irq) pending_d[sel] = 1'b0;
    req_nxt = |(pending_d & irq_en);
    count_d = count_q;
    if (irq && !(&count_q))
      count_d = count_q + CNT_W'(1);
  end

  // FSM next state, guard countdown and cause capture
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exc_taken)    state_d = ST_SERVICE;
        else if (req_nxt) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (irq) begin
          state_d = ST_SERVICE;
          cause_d = sel;
        end else if (exc_taken) begin
          state_d = ST_SERVICE;
        end else if (!req_nxt) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) begin
          state_d = ST_GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      ST_GUARD: begin
        if (exc_taken) begin
          state_d = ST_SERVICE;
        end else if (guard_q == '0) begin
          state_d = req_nxt ? ST_PENDING : ST_IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      src_q     <= '0;
      pending_q <= '0;
      state_q   <= ST_IDLE;
      guard_q   <= '0;
      cause_q   <= '0;
      count_q   <= '0;
    end else begin
      src_q     <= irq_src;
      pending_q <= pending_d;
      state_q   <= state_d;
      guard_q   <= guard_d;
      cause_q   <= cause_d;
      count_q   <= count_d;
    end
  end

  assign IRQ         = irq;
  assign in_service  = (state_q == ST_SERVICE) | irq
                     | exc_taken;
  assign irq_cause   = cause_q;
  assign irq_pending = pending_q;
  assign irq_count   = count_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer
// Expected causes queue up at stimulus, pop on each IRQ
module tb_irq_sequencer;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_src;
  logic [3:0]  irq_en;
  logic [3:0]  irq_clr;
  logic        id_valid;
  logic        stall;
  logic        branch_flush;
  logic        pc_kernel;
  logic        exc_taken;
  logic        eret;
  logic        IRQ;
  logic [1:0]  irq_cause;
  logic [3:0]  irq_pending;
  logic        in_service;
  logic [15:0] irq_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] sb[$];
  logic irq_d1;

  irq_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .irq_src      (irq_src),
    .irq_en       (irq_en),
    .irq_clr      (irq_clr),
    .id_valid     (id_valid),
    .stall        (stall),
    .branch_flush (branch_flush),
    .pc_kernel    (pc_kernel),
    .exc_taken    (exc_taken),
    .eret         (eret),
    .IRQ          (IRQ),
    .irq_cause    (irq_cause),
    .irq_pending  (irq_pending),
    .in_service   (in_service),
    .irq_count    (irq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic ret();
    nxt();
    eret = 1'b1;
    nxt();
    eret = 1'b0;
    nxt();
    nxt();
  endtask

  task automatic quiet();
    nxt();
    irq_src = 4'h0;
    nxt();
  endtask

  // scoreboard: cause after each pulse, plus pulse legality
  always @(negedge clk) begin
    if (!reset) begin
      irq_d1 <= 1'b0;
    end else begin
      if (irq_d1) begin
        if (sb.size() == 0) begin
          chk("unexpected_irq", 32'd1, 32'd0);
        end else begin
          chk("sb_cause", 32'(irq_cause),
              32'(sb.pop_front()));
        end
      end
      if (IRQ) begin
        chk("irq_slot_gate",
            32'(stall | branch_flush | pc_kernel),
            32'd0);
        chk("irq_back2back", 32'(irq_d1), 32'd0);
      end
      irq_d1 <= IRQ;
    end
  end

  initial begin
    reset = 1'b0;
    irq_src = 4'hF;
    irq_en = 4'hF;
    irq_clr = 4'h0;
    id_valid = 1'b0;
    stall = 1'b0;
    branch_flush = 1'b0;
    pc_kernel = 1'b0;
    exc_taken = 1'b0;
    eret = 1'b0;

    // reset held with sources high
    nxt();
    nxt();
    smp();
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_pend", 32'(irq_pending), 32'd0);
    chk("rst_cnt", 32'(irq_count), 32'd0);
    chk("rst_svc", 32'(in_service), 32'd0);
    nxt();
    reset = 1'b1;
    irq_en = 4'h0;
    id_valid = 1'b1;
    nxt();
    irq_en = 4'hF;
    smp();
    chk("hold_irq0", 32'(IRQ), 32'd0);
    nxt();
    smp();
    chk("hold_irq1", 32'(IRQ), 32'd0);
    chk("hold_pend", 32'(irq_pending), 32'd0);
    quiet();

    // basic injection and guard window
    nxt();
    irq_en = 4'h1;
    irq_src = 4'h1;
    sb.push_back(2'd0);
    smp();
    chk("b_t0_irq", 32'(IRQ), 32'd0);
    nxt();
    smp();
    chk("b_t1_irq", 32'(IRQ), 32'd1);
    chk("b_t1_svc", 32'(in_service), 32'd1);
    chk("b_t1_pend", 32'(irq_pending), 32'h1);
    nxt();
    smp();
    chk("b_t2_irq", 32'(IRQ), 32'd0);
    chk("b_t2_svc", 32'(in_service), 32'd1);
    chk("b_t2_cause", 32'(irq_cause), 32'd0);
    chk("b_t2_pend", 32'(irq_pending), 32'h0);
    chk("b_t2_cnt", 32'(irq_count), 32'd1);
    nxt();
    irq_en = 4'h3;
    irq_src = 4'h3;
    nxt();
    smp();
    chk("b_svc_pend", 32'(irq_pending), 32'h2);
    chk("b_svc_irq", 32'(IRQ), 32'd0);
    nxt();
    eret = 1'b1;
    sb.push_back(2'd1);
    nxt();
    eret = 1'b0;
    smp();
    chk("b_g1_irq", 32'(IRQ), 32'd0);
    chk("b_g1_svc", 32'(in_service), 32'd0);
    nxt();
    smp();
    chk("b_g2_irq", 32'(IRQ), 32'd0);
    nxt();
    smp();
    chk("b_post_irq", 32'(IRQ), 32'd1);
    nxt();
    smp();
    chk("b_post_cause", 32'(irq_cause), 32'd1);
    chk("b_post_cnt", 32'(irq_count), 32'd2);
    ret();
    quiet();

    // slot gating: stall, flush, kernel
    nxt();
    irq_en = 4'h2;
    irq_src = 4'h2;
    stall = 1'b1;
    sb.push_back(2'd1);
    smp();
    chk("g_idle_irq", 32'(IRQ), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      chk("g_stall_irq", 32'(IRQ), 32'd0);
    end
    nxt();
    stall = 1'b0;
    branch_flush = 1'b1;
    smp();
    chk("g_flush_irq", 32'(IRQ), 32'd0);
    nxt();
    branch_flush = 1'b0;
    pc_kernel = 1'b1;
    smp();
    chk("g_kern_irq", 32'(IRQ), 32'd0);
    chk("g_kern_pend", 32'(irq_pending), 32'h2);
    nxt();
    pc_kernel = 1'b0;
    smp();
    chk("g_open_irq", 32'(IRQ), 32'd1);
    nxt();
    smp();
    chk("g_cause", 32'(irq_cause), 32'd1);
    chk("g_cnt", 32'(irq_count), 32'd3);
    ret();
    quiet();

    // priority and accumulation
    nxt();
    irq_en = 4'h6;
    irq_src = 4'h6;
    sb.push_back(2'd1);
    sb.push_back(2'd2);
    nxt();
    smp();
    chk("p_first_irq", 32'(IRQ), 32'd1);
    nxt();
    smp();
    chk("p_first_cause", 32'(irq_cause), 32'd1);
    chk("p_first_pend", 32'(irq_pending), 32'h4);
    ret();
    smp();
    chk("p_second_irq", 32'(IRQ), 32'd1);
    nxt();
    smp();
    chk("p_second_cause", 32'(irq_cause), 32'd2);
    chk("p_cnt", 32'(irq_count), 32'd5);
    ret();
    quiet();

    // set/clear collision, clear while pending
    nxt();
    id_valid = 1'b0;
    irq_en = 4'h8;
    irq_src = 4'h8;
    irq_clr = 4'h8;
    nxt();
    irq_clr = 4'h0;
    smp();
    chk("c_set_wins", 32'(irq_pending), 32'h8);
    chk("c_irq0", 32'(IRQ), 32'd0);
    nxt();
    irq_clr = 4'h8;
    smp();
    chk("c_irq1", 32'(IRQ), 32'd0);
    nxt();
    irq_clr = 4'h0;
    id_valid = 1'b1;
    smp();
    chk("c_cleared", 32'(irq_pending), 32'h0);
    chk("c_irq2", 32'(IRQ), 32'd0);
    nxt();
    smp();
    chk("c_irq3", 32'(IRQ), 32'd0);

    // disabled source rise is dropped
    nxt();
    irq_src = 4'h0;
    nxt();
    irq_en = 4'h0;
    irq_src = 4'h8;
    nxt();
    smp();
    chk("d_drop", 32'(irq_pending), 32'h0);
    chk("d_irq", 32'(IRQ), 32'd0);
    quiet();

    // exception wins the race with a pending IRQ
    nxt();
    irq_en = 4'h8;
    irq_src = 4'h8;
    nxt();
    exc_taken = 1'b1;
    smp();
    chk("e_irq", 32'(IRQ), 32'd0);
    chk("e_svc", 32'(in_service), 32'd1);
    nxt();
    exc_taken = 1'b0;
    smp();
    chk("e_svc2", 32'(in_service), 32'd1);
    chk("e_pend", 32'(irq_pending), 32'h8);
    chk("e_cause", 32'(irq_cause), 32'd2);
    sb.push_back(2'd3);
    ret();
    smp();
    chk("e_late_irq", 32'(IRQ), 32'd1);
    nxt();
    smp();
    chk("e_late_cause", 32'(irq_cause), 32'd3);
    chk("e_cnt", 32'(irq_count), 32'd6);

    // reset while in service
    nxt();
    reset = 1'b0;
    nxt();
    reset = 1'b1;
    smp();
    chk("r_svc", 32'(in_service), 32'd0);
    chk("r_cnt", 32'(irq_count), 32'd0);
    chk("r_pend", 32'(irq_pending), 32'h0);
    chk("r_cause", 32'(irq_cause), 32'd0);
    nxt();
    irq_en = 4'h0;
    irq_src = 4'h0;
    nxt();
    nxt();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
